// File: rtl/ecap5_dproc_pkg.sv
// Shared types and constants for the core's memory-side blocks.
package ecap5_dproc_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_GRANT_M0,
      ARB_GRANT_M1
   } arb_state_t;

   localparam int ARB_NB_MASTERS = 2;

endpackage

// File: rtl/mem_arbiter_outstanding_counter.sv
// Tracks accepted-but-unacknowledged strobes for the current bus grant.
module outstanding_counter #(
   parameter int MAX = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic inc,
   input  logic dec,
   input  logic clear,
   output logic full,
   output logic empty
);

   localparam int CW = $clog2(MAX + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (inc && !dec)
         count <= count + 1'b1;
      else if (dec && !inc)
         count <= count - 1'b1;
   end

   assign full  = (count == CW'(MAX));
   assign empty = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Two-master pipelined Wishbone arbiter in front of the single memory port.
// Define MEM_ARBITER_RR_EN for round-robin tie breaking (default: m1 wins ties).
module mem_arbiter
   import ecap5_dproc_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] m0_wb_adr_i,
   input  logic        m0_wb_stb_i,
   input  logic        m0_wb_cyc_i,
   output logic [31:0] m0_wb_dat_o,
   output logic        m0_wb_ack_o,
   output logic        m0_wb_stall_o,
   input  logic [31:0] m1_wb_adr_i,
   input  logic [31:0] m1_wb_dat_i,
   input  logic [3:0]  m1_wb_sel_i,
   input  logic        m1_wb_we_i,
   input  logic        m1_wb_stb_i,
   input  logic        m1_wb_cyc_i,
   output logic [31:0] m1_wb_dat_o,
   output logic        m1_wb_ack_o,
   output logic        m1_wb_stall_o,
   output logic [31:0] s_wb_adr_o,
   output logic [31:0] s_wb_dat_o,
   output logic [3:0]  s_wb_sel_o,
   output logic        s_wb_we_o,
   output logic        s_wb_stb_o,
   output logic        s_wb_cyc_o,
   input  logic [31:0] s_wb_dat_i,
   input  logic        s_wb_ack_i,
   input  logic        s_wb_stall_i
);

   arb_state_t                state;
   logic [ARB_NB_MASTERS-1:0] cyc;
   logic                      pick_m1;
   logic                      hold_m0, hold_m1;
   logic                      hold_cyc, hold_stb;
   logic                      ack_fwd;
   logic                      full, empty;

   assign cyc = {m1_wb_cyc_i, m0_wb_cyc_i};

`ifdef MEM_ARBITER_RR_EN
   logic last_m1;
   // On a tie the master that did not hold the bus last goes first.
   assign pick_m1 = cyc[1] && (!cyc[0] || !last_m1);
`else
   assign pick_m1 = cyc[1];
`endif

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= ARB_IDLE;
`ifdef MEM_ARBITER_RR_EN
         last_m1 <= 1'b1;
`endif
      end else begin
         case (state)
            ARB_IDLE:
               if (|cyc) begin
                  state <= pick_m1 ? ARB_GRANT_M1 : ARB_GRANT_M0;
`ifdef MEM_ARBITER_RR_EN
                  last_m1 <= pick_m1;
`endif
               end
            ARB_GRANT_M0: if (!cyc[0]) state <= ARB_IDLE;
            ARB_GRANT_M1: if (!cyc[1]) state <= ARB_IDLE;
            default:      state <= ARB_IDLE;
         endcase
      end
   end

   assign hold_m0  = (state == ARB_GRANT_M0);
   assign hold_m1  = (state == ARB_GRANT_M1);
   assign hold_cyc = (hold_m0 && m0_wb_cyc_i) || (hold_m1 && m1_wb_cyc_i);
   assign hold_stb = (hold_m0 && m0_wb_stb_i) || (hold_m1 && m1_wb_stb_i);

   always_comb begin
      s_wb_adr_o = '0;
      s_wb_dat_o = '0;
      s_wb_sel_o = '0;
      s_wb_we_o  = 1'b0;
      case (state)
         ARB_GRANT_M0: begin
            s_wb_adr_o = m0_wb_adr_i;
            s_wb_sel_o = 4'hF;
         end
         ARB_GRANT_M1: begin
            s_wb_adr_o = m1_wb_adr_i;
            s_wb_dat_o = m1_wb_dat_i;
            s_wb_sel_o = m1_wb_sel_i;
            s_wb_we_o  = m1_wb_we_i;
         end
         default: ;
      endcase
   end

   assign s_wb_cyc_o = hold_cyc;
   assign s_wb_stb_o = hold_cyc && hold_stb && !full;

   // Acks with nothing outstanding, or after the holder dropped CYC, are discarded.
   assign ack_fwd = s_wb_ack_i && !empty && hold_cyc;

   assign m0_wb_ack_o   = hold_m0 && ack_fwd;
   assign m1_wb_ack_o   = hold_m1 && ack_fwd;
   assign m0_wb_stall_o = !hold_m0 || s_wb_stall_i || full;
   assign m1_wb_stall_o = !hold_m1 || s_wb_stall_i || full;
   assign m0_wb_dat_o   = s_wb_dat_i;
   assign m1_wb_dat_o   = s_wb_dat_i;

   outstanding_counter #(.MAX(MAX_OUTSTANDING)) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc   (s_wb_stb_o && !s_wb_stall_i),
      .dec   (ack_fwd),
      .clear (!hold_cyc),
      .full  (full),
      .empty (empty)
   );

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: slave model acks accepted strobes, monitor checks read data.
module tb_mem_arbiter;

   localparam int MAXO = 2;
`ifdef MEM_ARBITER_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk, rst_n;
   logic [31:0] m0_adr, m0_dat_o;
   logic        m0_stb, m0_cyc, m0_ack_o, m0_stall_o;
   logic [31:0] m1_adr, m1_dat, m1_dat_o;
   logic [3:0]  m1_sel;
   logic        m1_we, m1_stb, m1_cyc, m1_ack_o, m1_stall_o;
   logic [31:0] s_adr_o, s_dat_o, s_dat;
   logic [3:0]  s_sel_o;
   logic        s_we_o, s_stb_o, s_cyc_o, s_ack, s_stall;
   logic        ack_en;

   int n_chk = 0, n_err = 0;
   int ack_cnt0 = 0, ack_cnt1 = 0;
   logic [31:0] exp0[$], exp1[$], sq[$];

   mem_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
      .clk_i(clk), .rst_i(rst_n),
      .m0_wb_adr_i(m0_adr), .m0_wb_stb_i(m0_stb), .m0_wb_cyc_i(m0_cyc),
      .m0_wb_dat_o(m0_dat_o), .m0_wb_ack_o(m0_ack_o), .m0_wb_stall_o(m0_stall_o),
      .m1_wb_adr_i(m1_adr), .m1_wb_dat_i(m1_dat), .m1_wb_sel_i(m1_sel), .m1_wb_we_i(m1_we),
      .m1_wb_stb_i(m1_stb), .m1_wb_cyc_i(m1_cyc),
      .m1_wb_dat_o(m1_dat_o), .m1_wb_ack_o(m1_ack_o), .m1_wb_stall_o(m1_stall_o),
      .s_wb_adr_o(s_adr_o), .s_wb_dat_o(s_dat_o), .s_wb_sel_o(s_sel_o), .s_wb_we_o(s_we_o),
      .s_wb_stb_o(s_stb_o), .s_wb_cyc_o(s_cyc_o),
      .s_wb_dat_i(s_dat), .s_wb_ack_i(s_ack), .s_wb_stall_i(s_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rdata(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Slave: every accepted strobe is acked one cycle later while ack_en is high.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_ack <= 1'b0;
         s_dat <= '0;
         sq.delete();
      end else begin
         if (s_cyc_o && s_stb_o && !s_stall) sq.push_back(s_adr_o);
         if (ack_en && sq.size() > 0) begin
            s_ack <= 1'b1;
            s_dat <= rdata(sq.pop_front());
         end else begin
            s_ack <= 1'b0;
         end
      end
   end

   // Master-side scoreboard: push on accepted request, pop on ack.
   always @(negedge clk) begin
      if (rst_n) begin
         if (m0_cyc && m0_stb && !m0_stall_o) exp0.push_back(rdata(m0_adr));
         if (m1_cyc && m1_stb && !m1_stall_o) exp1.push_back(rdata(m1_adr));
         if (m0_ack_o) begin
            ack_cnt0++;
            if (exp0.size() == 0) chk("m0 spurious ack", 32'd1, 32'd0);
            else chk("m0 rdata", m0_dat_o, exp0.pop_front());
         end
         if (m1_ack_o) begin
            ack_cnt1++;
            if (exp1.size() == 0) chk("m1 spurious ack", 32'd1, 32'd0);
            else chk("m1 rdata", m1_dat_o, exp1.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic m_issue(input bit p, input logic [31:0] adr);
      int t = 0;
      if (p) begin m1_cyc = 1; m1_stb = 1; m1_adr = adr; end
      else   begin m0_cyc = 1; m0_stb = 1; m0_adr = adr; end
      forever begin
         @(negedge clk);
         if (!(p ? m1_stall_o : m0_stall_o)) break;
         if (++t > 50) begin chk("issue timeout", 32'd1, 32'd0); break; end
         tick();
      end
      tick();
   endtask

   task automatic drain(input bit p);
      int t = 0;
      while ((p ? exp1.size() : exp0.size()) > 0 && t < 100) begin
         tick();
         t++;
      end
      chk(p ? "m1 drain" : "m0 drain", 32'(p ? exp1.size() : exp0.size()), 32'd0);
   endtask

   task automatic tie_test(input bit exp_m1);
      m0_cyc = 1; m1_cyc = 1;
      tick();
      @(negedge clk);
      chk("tie winner", {31'b0, !m1_stall_o}, {31'b0, exp_m1});
      chk("tie loser stall", {31'b0, exp_m1 ? m0_stall_o : m1_stall_o}, 32'd1);
      tick();
      s_stall = 1;
      @(negedge clk);
      chk("slave stall passthru", {31'b0, exp_m1 ? m1_stall_o : m0_stall_o}, 32'd1);
      tick();
      s_stall = 0; m0_cyc = 0; m1_cyc = 0;
      tick();
      tick();
   endtask

   initial begin
      int a0, a1;
      rst_n = 0; ack_en = 1; s_stall = 0;
      m0_adr = 0; m0_stb = 0; m0_cyc = 1;
      m1_adr = 0; m1_dat = 0; m1_sel = 0; m1_we = 0; m1_stb = 0; m1_cyc = 1;

      // Reset with both masters requesting
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst s_cyc", {31'b0, s_cyc_o}, 32'd0);
      chk("rst s_stb", {31'b0, s_stb_o}, 32'd0);
      chk("rst m0 stall", {31'b0, m0_stall_o}, 32'd1);
      chk("rst m1 stall", {31'b0, m1_stall_o}, 32'd1);
      chk("rst acks", {30'b0, m1_ack_o, m0_ack_o}, 32'd0);
      chk("rst s_adr", s_adr_o, 32'd0);
      tick();
      rst_n = 1;
      @(negedge clk);
      chk("post-rst idle", {31'b0, s_cyc_o}, 32'd0);
      tick();
      @(negedge clk);
      chk("post-rst grant m1", {31'b0, !m1_stall_o}, {31'b0, !RR});
      tick();
      m0_cyc = 0; m1_cyc = 0;
      tick();
      tick();

      // m0 alone: three pipelined reads
      a0 = ack_cnt0; a1 = ack_cnt1;
      m0_cyc = 1;
      @(negedge clk);
      chk("m0 req cycle s_cyc", {31'b0, s_cyc_o}, 32'd0);
      chk("m0 req cycle stall", {31'b0, m0_stall_o}, 32'd1);
      tick();
      @(negedge clk);
      chk("m0 grant s_cyc", {31'b0, s_cyc_o}, 32'd1);
      chk("m0 sel", {28'b0, s_sel_o}, 32'hF);
      tick();
      m_issue(0, 32'h0);
      m_issue(0, 32'h4);
      m_issue(0, 32'h8);
      m0_stb = 0;
      drain(0);
      chk("m0 ack count", 32'(ack_cnt0 - a0), 32'd3);
      chk("m1 ack count", 32'(ack_cnt1 - a1), 32'd0);
      m0_cyc = 0;
      tick();
      tick();

      // Simultaneous request: m1 first, m0 two cycles after m1 releases
      m0_cyc = 1; m0_stb = 1; m0_adr = 32'h40;
      m1_cyc = 1; m1_stb = 1; m1_adr = 32'h80;
      @(negedge clk);
      chk("tie N m0 stall", {31'b0, m0_stall_o}, 32'd1);
      chk("tie N m1 stall", {31'b0, m1_stall_o}, 32'd1);
      tick();
      @(negedge clk);
      chk("tie N+1 m1 stall", {31'b0, m1_stall_o}, 32'd0);
      chk("tie N+1 m0 stall", {31'b0, m0_stall_o}, 32'd1);
      chk("tie N+1 s_adr", s_adr_o, 32'h80);
      tick();
      m1_stb = 0;
      drain(1);
      m1_cyc = 0;
      @(negedge clk);
      chk("release K s_cyc", {31'b0, s_cyc_o}, 32'd0);
      tick();
      @(negedge clk);
      chk("release K+1 s_cyc", {31'b0, s_cyc_o}, 32'd0);
      chk("release K+1 m0 stall", {31'b0, m0_stall_o}, 32'd1);
      tick();
      @(negedge clk);
      chk("release K+2 s_cyc", {31'b0, s_cyc_o}, 32'd1);
      chk("release K+2 s_adr", s_adr_o, 32'h40);
      chk("release K+2 m0 stall", {31'b0, m0_stall_o}, 32'd0);
      tick();
      m0_stb = 0;
      drain(0);
      m0_cyc = 0;
      tick();
      tick();

      tie_test(1'b1);
      tie_test(!RR);

      // Outstanding limit with acks withheld
      ack_en = 0;
      m_issue(1, 32'h200);
      m_issue(1, 32'h204);
      m1_adr = 32'h208;
      @(negedge clk);
      chk("full stall", {31'b0, m1_stall_o}, 32'd1);
      chk("full s_stb", {31'b0, s_stb_o}, 32'd0);
      tick();
      ack_en = 1;
      tick();
      ack_en = 0;
      @(negedge clk);
      chk("full+ack fwd", {31'b0, m1_ack_o}, 32'd1);
      chk("full+ack stall", {31'b0, m1_stall_o}, 32'd1);
      chk("full+ack s_stb", {31'b0, s_stb_o}, 32'd0);
      tick();
      @(negedge clk);
      chk("after ack s_stb", {31'b0, s_stb_o}, 32'd1);
      chk("after ack stall", {31'b0, m1_stall_o}, 32'd0);
      tick();
      m1_stb = 0;
      ack_en = 1;
      drain(1);
      m1_cyc = 0;
      tick();
      tick();

      // m1 write, then abort with one strobe outstanding
      ack_en = 0;
      m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h100; m1_dat = 32'hDEADBEEF; m1_sel = 4'b0011;
      tick();
      @(negedge clk);
      chk("wr s_we", {31'b0, s_we_o}, 32'd1);
      chk("wr s_adr", s_adr_o, 32'h100);
      chk("wr s_dat", s_dat_o, 32'hDEADBEEF);
      chk("wr s_sel", {28'b0, s_sel_o}, 32'h3);
      chk("wr s_stb", {31'b0, s_stb_o}, 32'd1);
      tick();
      m1_stb = 0; m1_cyc = 0; m1_we = 0;
      exp1.delete();
      ack_en = 1;
      @(negedge clk);
      chk("abort s_cyc", {31'b0, s_cyc_o}, 32'd0);
      tick();
      @(negedge clk);
      chk("late ack dropped", {31'b0, m1_ack_o}, 32'd0);
      tick();
      ack_en = 0;
      m_issue(1, 32'h300);
      m1_adr = 32'h304;
      @(negedge clk);
      chk("count cleared", {31'b0, m1_stall_o}, 32'd0);
      tick();
      m1_stb = 0;
      ack_en = 1;
      drain(1);
      m1_cyc = 0;
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master to one-slave pipelined Wishbone arbiter sharing the single memory port between the instruction fetch path (port 0, read-only) and the load/store path (port 1, read/write). Grants the bus to one master per Wishbone cycle (CYC envelope), steers slave responses back to the grant holder, and bounds in-flight transactions per grant. Sits between `ifm`/load-store unit and the memory slave at the core boundary.

## Interface
- MAX_OUTSTANDING, 4, max accepted-but-unacknowledged strobes per grant (1..15); counter width $clog2(MAX_OUTSTANDING+1)
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- m0_wb_adr_i / m0_wb_stb_i / m0_wb_cyc_i  in  32/1/1  instruction master request
- m0_wb_dat_o / m0_wb_ack_o / m0_wb_stall_o  out  32/1/1  instruction master response
- m1_wb_adr_i / m1_wb_dat_i / m1_wb_sel_i / m1_wb_we_i / m1_wb_stb_i / m1_wb_cyc_i  in  32/32/4/1/1/1  data master request
- m1_wb_dat_o / m1_wb_ack_o / m1_wb_stall_o  out  32/1/1  data master response
- s_wb_adr_o / s_wb_dat_o / s_wb_sel_o / s_wb_we_o / s_wb_stb_o / s_wb_cyc_o  out  32/32/4/1/1/1  slave request
- s_wb_dat_i / s_wb_ack_i / s_wb_stall_i  in  32/1/1  slave response

## Operation
- States: IDLE, GRANT_M0, GRANT_M1 (registered).
- IDLE: if any mN_wb_cyc_i high, move to GRANT of winner. Fixed priority: m1 beats m0 on simultaneous request.
- GRANT_Mx: stay while mx_wb_cyc_i high; when it drops, go to IDLE next edge. No preemption.
- Slave request mux: adr/dat/sel/we from grant holder; port 0 drives we=0, sel=4'hF, dat=0. s_wb_cyc_o = holder cyc_i (combinational, drops same cycle master drops). In IDLE all slave request outputs 0.
- s_wb_stb_o = holder stb_i & !full; full = (count == MAX_OUTSTANDING).
- Holder stall_o = s_wb_stall_i | full. Non-holder stall_o = 1, ack_o = 0.
- mN_wb_dat_o = s_wb_dat_i on both ports (qualified by ack).
- Holder ack_o = s_wb_ack_i & (count != 0); ack with count 0 is spurious, dropped.
- Counter: +1 on accepted strobe (s_wb_stb_o & !s_wb_stall_i), -1 on forwarded ack, unchanged on both; cleared on return to IDLE (abort: late acks after CYC drop never forwarded).

## Timing
- Reset (async assert): state IDLE, count 0; s_wb_cyc_o/stb_o/we_o = 0, adr/dat/sel = 0; m0/m1 ack_o = 0, stall_o = 1. Reset mid-cycle aborts the transfer immediately.
- Grant latency: cyc_i rising in cycle N (IDLE) -> s_wb_cyc_o/stb_o in N+1; master sees stall=1 in N and must hold stb/adr.
- Release: cyc_i low in cycle K -> s_wb_cyc_o low in K, IDLE in K+1, next grant visible K+2 (minimum 2 idle bus cycles between grants).
- Ack passes combinationally slave->holder, zero added latency; stall likewise.
- Full boundary: at count == MAX with ack in same cycle, stall still asserted that cycle; strobe accepted next cycle.

## Configuration
- MEM_ARBITER_RR_EN defined: round-robin — on simultaneous request in IDLE, the master not granted last wins; last-granted register resets to m1 (so m0 wins first tie). Single requester always wins.
- Not defined: fixed priority, m1 always wins ties; last-granted register absent.

## Structure
- Shared package `ecap5_dproc_pkg`: `arb_state_t` enum {ARB_IDLE, ARB_GRANT_M0, ARB_GRANT_M1}, constant `ARB_NB_MASTERS = 2`.
- One sub-module `outstanding_counter` (parameter MAX; inc/dec/clear inputs, full/empty outputs).

## Test plan
- Reset: rst_i low with both cyc high -> s_wb_cyc_o=0, both stall_o=1, ack_o=0; release -> grant m1 one cycle later.
- m0 alone, 3 pipelined reads adr 0x0/0x4/0x8, slave ack 1 cycle later -> s_wb_cyc_o rises cycle after request, 3 acks to m0, m1 ack_o stays 0.
- Both request cycle N -> m1 granted N+1; m0 stalled until m1 drops cyc at K, m0 on slave at K+2; with MEM_ARBITER_RR_EN, second tie goes to m0 first.
- MAX_OUTSTANDING=2, slave withholds acks -> third strobe stalled, s_wb_stb_o=0; one ack -> strobe accepted next cycle.
- m1 write adr 0x100 dat 0xDEADBEEF sel 4'b0011 -> slave sees we=1, same adr/dat/sel; m1 drops cyc with 1 outstanding, late ack -> not forwarded, count 0.
